ball_ctrl: RTL and testbench

- Ball motion and collision engine for the pong game.
- Moves a ball across a FIELD_W x FIELD_H grid and bounces it off the top/bottom walls and both paddles.
- Emits the Lftcollision/Rgtcollision miss pulses consumed by the score keeper.
- Reads Lftwin/Rgtwin back from the score keeper to freeze play at game over.

---
 rtl/ball_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_ball_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_ctrl.sv
// Pong ball motion and collision engine: serve delay, wall/paddle bounces, miss and hit pulses, game-over freeze.
// Optional BALL_SPEEDUP_EN shortens the tick period by one clock every 4th paddle hit (floor 1).
module ball_ctrl #(
    parameter int FIELD_W    = 64,
    parameter int FIELD_H    = 32,
    parameter int X_W        = 6,
    parameter int Y_W        = 5,
    parameter int PADDLE_H   = 8,
    parameter int TICK_DIV   = 4,
    parameter int SERVE_WAIT = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [Y_W-1:0] lft_pad,
    input  logic [Y_W-1:0] rgt_pad,
    input  logic           Lftwin,
    input  logic           Rgtwin,
    output logic [X_W-1:0] ball_x,
    output logic [Y_W-1:0] ball_y,
    output logic           Lftcollision,
    output logic           Rgtcollision,
    output logic           Lfthit,
    output logic           Rgthit,
    output logic           playing
);

    localparam int DIV_W = $clog2(TICK_DIV + 1);
    localparam int SRV_W = $clog2(SERVE_WAIT + 1);

    localparam logic [X_W-1:0] X_CTR   = X_W'(FIELD_W / 2);
    localparam logic [X_W-1:0] X_LWALL = X_W'(0);
    localparam logic [X_W-1:0] X_LPAD  = X_W'(1);
    localparam logic [X_W-1:0] X_LRET  = X_W'(2);
    localparam logic [X_W-1:0] X_RRET  = X_W'(FIELD_W - 3);
    localparam logic [X_W-1:0] X_RPAD  = X_W'(FIELD_W - 2);
    localparam logic [X_W-1:0] X_RWALL = X_W'(FIELD_W - 1);

    localparam logic [Y_W-1:0] Y_CTR   = Y_W'(FIELD_H / 2);
    localparam logic [Y_W-1:0] Y_MAX   = Y_W'(FIELD_H - 1);
    localparam logic [Y_W-1:0] Y_MAXM1 = Y_W'(FIELD_H - 2);
    localparam logic [Y_W-1:0] PAD_MAX = Y_W'(FIELD_H - PADDLE_H);
    localparam logic [Y_W:0]   PAD_SPAN = (Y_W + 1)'(PADDLE_H - 1);

    localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(TICK_DIV);
    localparam logic [SRV_W-1:0] SRV_LAST = SRV_W'(SERVE_WAIT - 1);

    typedef enum logic [1:0] {
        S_SERVE  = 2'd0,
        S_MOVE   = 2'd1,
        S_SCORED = 2'd2,
        S_OVER   = 2'd3
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_presc;
    logic [SRV_W-1:0] r_serve;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic             r_dx_right;
    logic             r_dy_down;
    logic             r_lcol;
    logic             r_rcol;
    logic             r_lhit;
    logic             r_rhit;

    state_t           w_state_nx;
    logic [SRV_W-1:0] w_serve_nx;
    logic [X_W-1:0]   w_x_nx;
    logic [Y_W-1:0]   w_y_nx;
    logic             w_dx_nx;
    logic             w_dy_nx;
    logic             w_lcol_nx;
    logic             w_rcol_nx;
    logic             w_lhit_nx;
    logic             w_rhit_nx;

    logic [DIV_W-1:0] w_div;
    logic             w_tick;
    logic [Y_W-1:0]   w_lpad;
    logic [Y_W-1:0]   w_rpad;
    logic             w_lin;
    logic             w_rin;

`ifdef BALL_SPEEDUP_EN
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_hits;

    // Divider and hit count restart with every new rally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div  <= DIV_INIT;
            r_hits <= 2'd0;
        end else if (r_state == S_SCORED) begin
            r_div  <= DIV_INIT;
            r_hits <= 2'd0;
        end else if (w_lhit_nx || w_rhit_nx) begin
            r_hits <= r_hits + 2'd1;
            if (r_hits == 2'd3 && r_div > DIV_W'(1)) begin
                r_div <= r_div - DIV_W'(1);
            end
        end
    end

    assign w_div = r_div;
`else
    assign w_div = DIV_INIT;
`endif

    // ">=" keeps the prescaler safe if the divider ever shrinks below the count.
    assign w_tick = (r_presc >= (w_div - DIV_W'(1)));

    assign w_lpad = (lft_pad > PAD_MAX) ? PAD_MAX : lft_pad;
    assign w_rpad = (rgt_pad > PAD_MAX) ? PAD_MAX : rgt_pad;
    assign w_lin  = (r_y >= w_lpad) && ({1'b0, r_y} <= ({1'b0, w_lpad} + PAD_SPAN));
    assign w_rin  = (r_y >= w_rpad) && ({1'b0, r_y} <= ({1'b0, w_rpad} + PAD_SPAN));

    always_comb begin
        w_state_nx = r_state;
        w_serve_nx = r_serve;
        w_x_nx     = r_x;
        w_y_nx     = r_y;
        w_dx_nx    = r_dx_right;
        w_dy_nx    = r_dy_down;
        w_lcol_nx  = 1'b0;
        w_rcol_nx  = 1'b0;
        w_lhit_nx  = 1'b0;
        w_rhit_nx  = 1'b0;
        case (r_state)
            S_SERVE: begin
                w_x_nx = X_CTR;
                w_y_nx = Y_CTR;
                if (Lftwin || Rgtwin) begin
                    w_state_nx = S_OVER;
                end else if (w_tick) begin
                    if (r_serve == SRV_LAST) begin
                        w_serve_nx = '0;
                        w_state_nx = S_MOVE;
                    end else begin
                        w_serve_nx = r_serve + SRV_W'(1);
                    end
                end
            end
            S_MOVE: begin
                if (w_tick) begin
                    if (!r_dx_right && r_x == X_LPAD) begin
                        if (w_lin) begin
                            w_dx_nx   = 1'b1;
                            w_x_nx    = X_LRET;
                            w_lhit_nx = 1'b1;
                        end else begin
                            w_x_nx     = X_LWALL;
                            w_lcol_nx  = 1'b1;
                            w_state_nx = S_SCORED;
                        end
                    end else if (r_dx_right && r_x == X_RPAD) begin
                        if (w_rin) begin
                            w_dx_nx   = 1'b0;
                            w_x_nx    = X_RRET;
                            w_rhit_nx = 1'b1;
                        end else begin
                            w_x_nx     = X_RWALL;
                            w_rcol_nx  = 1'b1;
                            w_state_nx = S_SCORED;
                        end
                    end else if (r_dx_right) begin
                        w_x_nx = r_x + X_W'(1);
                    end else begin
                        w_x_nx = r_x - X_W'(1);
                    end

                    if (!r_dy_down && r_y == '0) begin
                        w_dy_nx = 1'b1;
                        w_y_nx  = Y_W'(1);
                    end else if (r_dy_down && r_y == Y_MAX) begin
                        w_dy_nx = 1'b0;
                        w_y_nx  = Y_MAXM1;
                    end else if (r_dy_down) begin
                        w_y_nx = r_y + Y_W'(1);
                    end else begin
                        w_y_nx = r_y - Y_W'(1);
                    end
                end
            end
            S_SCORED: begin
                // Ball sits on the wall of the player who missed; serve toward that player.
                w_x_nx     = X_CTR;
                w_y_nx     = Y_CTR;
                w_dx_nx    = (r_x != X_LWALL);
                w_serve_nx = '0;
                w_state_nx = S_SERVE;
            end
            S_OVER: begin
                w_state_nx = S_OVER;
            end
            default: begin
                w_state_nx = S_SERVE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_SERVE;
            r_presc    <= '0;
            r_serve    <= '0;
            r_x        <= X_CTR;
            r_y        <= Y_CTR;
            r_dx_right <= 1'b1;
            r_dy_down  <= 1'b1;
            r_lcol     <= 1'b0;
            r_rcol     <= 1'b0;
            r_lhit     <= 1'b0;
            r_rhit     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_presc    <= w_tick ? '0 : (r_presc + DIV_W'(1));
            r_serve    <= w_serve_nx;
            r_x        <= w_x_nx;
            r_y        <= w_y_nx;
            r_dx_right <= w_dx_nx;
            r_dy_down  <= w_dy_nx;
            r_lcol     <= w_lcol_nx;
            r_rcol     <= w_rcol_nx;
            r_lhit     <= w_lhit_nx;
            r_rhit     <= w_rhit_nx;
        end
    end

    assign ball_x       = r_x;
    assign ball_y       = r_y;
    assign Lftcollision = r_lcol;
    assign Rgtcollision = r_rcol;
    assign Lfthit       = r_lhit;
    assign Rgthit       = r_rhit;
    assign playing      = (r_state != S_OVER);

endmodule

// File: tb/tb_ball_ctrl.sv
// Bench for ball_ctrl: directed trajectory with hand-computed positions, then randomized rallies
// checked every cycle against a position/direction model of the game rules.
module tb_ball_ctrl;

    localparam int FIELD_W    = 64;
    localparam int FIELD_H    = 32;
    localparam int X_W        = 6;
    localparam int Y_W        = 5;
    localparam int PADDLE_H   = 8;
    localparam int TICK_DIV   = 4;
    localparam int SERVE_WAIT = 8;
    localparam int PAD_MAX    = FIELD_H - PADDLE_H;

    localparam int PH_SERVE  = 0;
    localparam int PH_MOVE   = 1;
    localparam int PH_SCORED = 2;
    localparam int PH_OVER   = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [Y_W-1:0] lft_pad = '0;
    logic [Y_W-1:0] rgt_pad = '0;
    logic           Lftwin = 1'b0;
    logic           Rgtwin = 1'b0;
    logic [X_W-1:0] ball_x;
    logic [Y_W-1:0] ball_y;
    logic           Lftcollision;
    logic           Rgtcollision;
    logic           Lfthit;
    logic           Rgthit;
    logic           playing;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // model state
    int m_x, m_y, m_dx, m_dy, m_cnt, m_div, m_hits, m_serve, m_phase;
    bit m_lcol, m_rcol, m_lhit, m_rhit;

    ball_ctrl #(
        .FIELD_W(FIELD_W), .FIELD_H(FIELD_H), .X_W(X_W), .Y_W(Y_W),
        .PADDLE_H(PADDLE_H), .TICK_DIV(TICK_DIV), .SERVE_WAIT(SERVE_WAIT)
    ) dut (
        .clk(clk), .reset(reset), .lft_pad(lft_pad), .rgt_pad(rgt_pad),
        .Lftwin(Lftwin), .Rgtwin(Rgtwin), .ball_x(ball_x), .ball_y(ball_y),
        .Lftcollision(Lftcollision), .Rgtcollision(Rgtcollision),
        .Lfthit(Lfthit), .Rgthit(Rgthit), .playing(playing)
    );

    // clock / reset
    initial forever #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clamp_pad(input int p);
        return (p > PAD_MAX) ? PAD_MAX : p;
    endfunction

    function automatic bit covers(input int pad, input int y);
        return (y >= pad) && (y <= pad + PADDLE_H - 1);
    endfunction

    // reference model: ball as signed coordinates with +1/-1 velocities
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_x = FIELD_W / 2; m_y = FIELD_H / 2; m_dx = 1; m_dy = 1;
            m_cnt = 0; m_div = TICK_DIV; m_hits = 0; m_serve = 0; m_phase = PH_SERVE;
            m_lcol = 0; m_rcol = 0; m_lhit = 0; m_rhit = 0;
        end else begin
            int  nx, ny;
            bit  tick;
            m_lcol = 0; m_rcol = 0; m_lhit = 0; m_rhit = 0;
            tick  = (m_cnt == m_div - 1);
            m_cnt = tick ? 0 : m_cnt + 1;
            case (m_phase)
                PH_SERVE: begin
                    if (Lftwin || Rgtwin) m_phase = PH_OVER;
                    else if (tick) begin
                        m_serve++;
                        if (m_serve == SERVE_WAIT) begin
                            m_serve = 0;
                            m_phase = PH_MOVE;
                        end
                    end
                end
                PH_MOVE: if (tick) begin
                    nx = m_x + m_dx;
                    if (nx == 0) begin
                        if (covers(clamp_pad(int'(lft_pad)), m_y)) begin
                            m_dx = 1; m_x = 2; m_lhit = 1;
                        end else begin
                            m_x = 0; m_lcol = 1; m_phase = PH_SCORED;
                        end
                    end else if (nx == FIELD_W - 1) begin
                        if (covers(clamp_pad(int'(rgt_pad)), m_y)) begin
                            m_dx = -1; m_x = FIELD_W - 3; m_rhit = 1;
                        end else begin
                            m_x = FIELD_W - 1; m_rcol = 1; m_phase = PH_SCORED;
                        end
                    end else begin
                        m_x = nx;
                    end
                    ny = m_y + m_dy;
                    if (ny < 0) begin
                        m_dy = 1; m_y = 1;
                    end else if (ny > FIELD_H - 1) begin
                        m_dy = -1; m_y = FIELD_H - 2;
                    end else begin
                        m_y = ny;
                    end
`ifdef BALL_SPEEDUP_EN
                    if (m_lhit || m_rhit) begin
                        m_hits++;
                        if (m_hits % 4 == 0 && m_div > 1) m_div--;
                    end
`endif
                end
                PH_SCORED: begin
                    m_dx = (m_x == 0) ? -1 : 1;
                    m_x = FIELD_W / 2; m_y = FIELD_H / 2;
                    m_serve = 0; m_phase = PH_SERVE;
`ifdef BALL_SPEEDUP_EN
                    m_div = TICK_DIV; m_hits = 0;
`endif
                end
                default: ;
            endcase
        end
    end

    // scoreboard: every-cycle compare on the falling edge
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("ball_x", int'(ball_x), m_x);
            chk("ball_y", int'(ball_y), m_y);
            chk("Lftcollision", int'(Lftcollision), int'(m_lcol));
            chk("Rgtcollision", int'(Rgtcollision), int'(m_rcol));
            chk("Lfthit", int'(Lfthit), int'(m_lhit));
            chk("Rgthit", int'(Rgthit), int'(m_rhit));
            chk("playing", int'(playing), int'(m_phase != PH_OVER));
        end
    end

    // driver tasks
    task automatic go_neg(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_centre_idle(input string tag);
        chk({tag, "_x"}, int'(ball_x), FIELD_W / 2);
        chk({tag, "_y"}, int'(ball_y), FIELD_H / 2);
        chk({tag, "_pulses"}, int'({Lftcollision, Rgtcollision, Lfthit, Rgthit}), 0);
        chk({tag, "_playing"}, int'(playing), 1);
    endtask

    task automatic run_episode(input int cycles);
        int mode;
        bit won;
        @(posedge clk);
        #1 reset = 1'b1;
        #1 chk_centre_idle("async_rst");
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        reset  = 1'b0;
        Lftwin = 1'b0;
        Rgtwin = 1'b0;
        won    = 1'b0;
        mode   = $urandom_range(0, 2);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            if (mode == 0 || (mode == 2 && $urandom_range(0, 9) == 0)) begin
                lft_pad = Y_W'($urandom_range(0, FIELD_H - 1));
                rgt_pad = Y_W'($urandom_range(0, FIELD_H - 1));
            end else begin
                int lp, rp;
                lp = m_y - int'($urandom_range(0, PADDLE_H - 1));
                rp = m_y - int'($urandom_range(0, PADDLE_H - 1));
                lft_pad = Y_W'((lp < 0) ? 0 : lp);
                rgt_pad = Y_W'((rp < 0) ? 0 : rp);
            end
            if (!won && $urandom_range(0, 1999) == 0) begin
                won = 1'b1;
                case ($urandom_range(0, 2))
                    0: Lftwin = 1'b1;
                    1: Rgtwin = 1'b1;
                    default: begin Lftwin = 1'b1; Rgtwin = 1'b1; end
                endcase
            end
        end
    endtask

    // directed sequence, then randomized rallies
    initial begin
        lft_pad = Y_W'(12);
        rgt_pad = Y_W'(12);
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk_centre_idle("reset");
        reset = 1'b0;

        go_neg(35);
        chk_centre_idle("serve_hold");
        go_neg(1);
        chk("first_move_x", int'(ball_x), 33);
        chk("first_move_y", int'(ball_y), 17);
        go_neg(56);
        chk("bottom_y", int'(ball_y), 31);
        go_neg(4);
        chk("bottom_bounce_y", int'(ball_y), 30);
        go_neg(56);
        chk("at_rpad_x", int'(ball_x), 62);
        chk("at_rpad_y", int'(ball_y), 16);
        go_neg(4);
        chk("rgthit", int'(Rgthit), 1);
        chk("rgthit_x", int'(ball_x), 61);
        chk("rgthit_y", int'(ball_y), 15);
        lft_pad = Y_W'(0);
        go_neg(240);
        chk("at_lpad_x", int'(ball_x), 1);
        chk("at_lpad_y", int'(ball_y), 17);
        go_neg(4);
        chk("lftmiss_pulse", int'(Lftcollision), 1);
        chk("lftmiss_hit", int'(Lfthit), 0);
        chk("lftmiss_x", int'(ball_x), 0);
        go_neg(1);
        chk("recentre_x", int'(ball_x), 32);
        chk("recentre_pulse", int'(Lftcollision), 0);
        go_neg(34);
        chk("reserve_hold_x", int'(ball_x), 32);
        go_neg(1);
        chk("reserve_move_x", int'(ball_x), 31);
        chk("reserve_move_y", int'(ball_y), 15);

        // game over freeze and recovery
        reset = 1'b1;
        go_neg(1);
        reset = 1'b0;
        go_neg(10);
        Rgtwin = 1'b1;
        go_neg(1);
        chk("over_playing", int'(playing), 0);
        go_neg(200);
        chk("over_frozen_x", int'(ball_x), 32);
        chk("over_frozen_y", int'(ball_y), 16);
        chk("over_playing_late", int'(playing), 0);
        reset = 1'b1;
        #1 chk("over_reset_playing", int'(playing), 1);
        go_neg(1);
        reset  = 1'b0;
        Rgtwin = 1'b0;
        go_neg(1);
        chk_centre_idle("after_over");

        for (int e = 0; e < 30; e++) begin
            run_episode(600);
        end
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
